// File: rtl/param_up_down_counter.sv
// param_up_down_counter: parametrised modulo-(MAX+1) up/down counter with
// variable step, synchronous parallel load, count enable, registered
// carry/borrow pulses and combinational at_max/at_zero status.
//
// Optional build macro: PARAM_UP_DOWN_COUNTER_SATURATE_EN
//   undefined (default): an up/down step past MAX/0 wraps modulo MAX+1.
//   defined            : the counter clamps at MAX/0 instead of wrapping;
//                        carry/borrow still pulse to flag each clamp event.
module param_up_down_counter #(
  parameter int          WIDTH = 4,
  parameter int unsigned MAX   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down_flag,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] counter,
  output logic             carry,
  output logic             borrow,
  output logic             at_max,
  output logic             at_zero
);

  // One extra bit of headroom so MAX+1 and counter+step never overflow.
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] MODULUS = (WIDTH+1)'(MAX + 1);

  logic [WIDTH:0]   counter_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   eff_step;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH-1:0] next_counter;
  logic             next_carry;
  logic             next_borrow;

  assign counter_ext = {1'b0, counter};
  assign step_ext    = {1'b0, step};
  assign load_ext    = {1'b0, load_value};

  // A step larger than the modulus range is treated as MAX.
  assign eff_step = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
  assign sum_up   = counter_ext + eff_step;

  assign at_max  = (counter_ext == MAX_EXT);
  assign at_zero = (counter == '0);

  // Next-state selection: load beats enable; otherwise hold with no pulses.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    next_counter = counter;
    next_carry   = 1'b0;
    next_borrow  = 1'b0;

    if (load) begin
      next_counter = (load_ext > MAX_EXT) ? WIDTH'(MAX_EXT) : load_value;
    end else if (enable) begin
      if (up_down_flag) begin
        if (sum_up > MAX_EXT) begin
          next_carry = 1'b1;
`ifdef PARAM_UP_DOWN_COUNTER_SATURATE_EN
          next_counter = WIDTH'(MAX_EXT);
`else
          next_counter = WIDTH'(sum_up - MODULUS);
`endif
        end else begin
          next_counter = WIDTH'(sum_up);
        end
      end else begin
        if (eff_step > counter_ext) begin
          next_borrow = 1'b1;
`ifdef PARAM_UP_DOWN_COUNTER_SATURATE_EN
          next_counter = '0;
`else
          next_counter = WIDTH'(counter_ext + MODULUS - eff_step);
`endif
        end else begin
          next_counter = WIDTH'(counter_ext - eff_step);
        end
      end
    end
  end

  // State register with synchronous active-low reset overriding everything.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (!reset) begin
      counter <= '0;
      carry   <= 1'b0;
      borrow  <= 1'b0;
    end else begin
      counter <= next_counter;
      carry   <= next_carry;
      borrow  <= next_borrow;
    end
  end

endmodule
